fetch_realigner: RTL and testbench

Sits between the instruction fetch stage and `compressed_decoder`. Takes aligned 32-bit fetch words and emits one raw instruction per handshake, with its exact address:
- 16-bit compressed instructions are zero-extended to 32 bits.
- 32-bit instructions are reassembled, including those that straddle a word boundary.

It handles two compressed instructions per word, halfword-aligned jump targets and flushes. The instruction it emits goes straight into the compressed decoder's input.

---
 rtl/riscv_pkg.sv | 10 +
 rtl/fetch_realigner.sv | 138 +++++++++++++
 tb/tb_fetch_realigner.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V helpers used by the fetch, realign and decode stages.
//   is_rvc(): true when a 16-bit parcel starts a compressed instruction.
package riscv_pkg;

  // A parcel is compressed unless its two lowest bits are both set.
  function automatic logic is_rvc(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_realigner.sv
// Realigns aligned 32-bit fetch words into one raw instruction per handshake.
// Compressed parcels are zero-extended. 32-bit instructions that straddle a
// word boundary are stitched together from a carried upper halfword.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   flush_i               drop all buffered state, accept nothing this cycle
//   fetch_valid_i/ready_o fetch-side handshake
//   fetch_data_i          fetch word, little-endian halfwords
//   fetch_addr_i          address of first useful halfword (bit 1 may be set)
//   instr_valid_o/ready_i decode-side handshake
//   instr_o               raw instruction, upper half zero when compressed
//   instr_addr_o          address of the instruction's first halfword
//   instr_is_rvc_o        instruction is compressed
module fetch_realigner
  import riscv_pkg::*;
#(
  parameter int unsigned VLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_data_i,
  input  logic [VLEN-1:0] fetch_addr_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [VLEN-1:0] instr_addr_o,
  output logic            instr_is_rvc_o
);

  typedef struct packed {
    logic [31:0]     data;
    logic [VLEN-1:0] addr;
    logic            vld;
  } word_buf_t;

  typedef struct packed {
    logic [15:0]     data;
    logic [VLEN-1:0] addr;
    logic            vld;
  } carry_buf_t;

  word_buf_t  word_q, word_d;
  carry_buf_t carry_q, carry_d;
  logic       ptr_q, ptr_d;

  logic consumed;   // buffered word fully used this cycle
  logic carry_new;  // upper halfword moves into the carry this cycle

  // Bit 0 of the fetch address is always zero for halfword-aligned fetch.
  logic unused_addr_bit0;
  assign unused_addr_bit0 = fetch_addr_i[0];

  always_comb begin
    word_d        = word_q;
    carry_d       = carry_q;
    ptr_d         = ptr_q;
    instr_valid_o = 1'b0;
    instr_o       = '0;
    instr_addr_o  = '0;
    consumed      = 1'b0;
    carry_new     = 1'b0;

    if (word_q.vld) begin
      if (carry_q.vld) begin
        // Finish a straddling instruction with the lower half of this word.
        instr_valid_o = 1'b1;
        instr_o       = {word_q.data[15:0], carry_q.data};
        instr_addr_o  = carry_q.addr;
        if (instr_ready_i) begin
          carry_d.vld = 1'b0;
          ptr_d       = 1'b1;
        end
      end else if (!ptr_q) begin
        instr_valid_o = 1'b1;
        instr_addr_o  = word_q.addr;
        if (is_rvc(word_q.data[15:0])) begin
          instr_o = {16'h0000, word_q.data[15:0]};
          if (instr_ready_i) ptr_d = 1'b1;
        end else begin
          instr_o = word_q.data;
          if (instr_ready_i) consumed = 1'b1;
        end
      end else if (is_rvc(word_q.data[31:16])) begin
        instr_valid_o = 1'b1;
        instr_o       = {16'h0000, word_q.data[31:16]};
        instr_addr_o  = word_q.addr + VLEN'(2);
        if (instr_ready_i) consumed = 1'b1;
      end else begin
        // Upper half starts a 32-bit instruction: park it, no output.
        carry_new    = 1'b1;
        consumed     = 1'b1;
        carry_d.data = word_q.data[31:16];
        carry_d.addr = word_q.addr + VLEN'(2);
        carry_d.vld  = 1'b1;
      end
    end

    if (consumed) begin
      word_d.vld = 1'b0;
      ptr_d      = 1'b0;
    end

    fetch_ready_o = !flush_i && (!word_q.vld || consumed);

    if (fetch_valid_i && fetch_ready_o) begin
      word_d.data = fetch_data_i;
      word_d.addr = {fetch_addr_i[VLEN-1:2], 2'b00};
      word_d.vld  = 1'b1;
      // A pending carry always continues at the lower half of the next word.
      ptr_d       = (carry_q.vld || carry_new) ? 1'b0 : fetch_addr_i[1];
    end

    if (flush_i) begin
      word_d.vld  = 1'b0;
      carry_d.vld = 1'b0;
      ptr_d       = 1'b0;
    end

    instr_is_rvc_o = instr_valid_o && is_rvc(instr_o[15:0]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q  <= '0;
      carry_q <= '0;
      ptr_q   <= 1'b0;
    end else begin
      word_q  <= word_d;
      carry_q <= carry_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_fetch_realigner.sv
// Bench for fetch_realigner: table-driven fetch words with a scoreboard of
// expected instructions, plus hand-written stall, flush and reset sequences.
module tb_fetch_realigner;

  localparam int unsigned VLEN = 64;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            fetch_valid_i;
  logic            fetch_ready_o;
  logic [31:0]     fetch_data_i;
  logic [VLEN-1:0] fetch_addr_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [31:0]     instr_o;
  logic [VLEN-1:0] instr_addr_o;
  logic            instr_is_rvc_o;

  fetch_realigner #(.VLEN(VLEN)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_ready_o  (fetch_ready_o),
    .fetch_data_i   (fetch_data_i),
    .fetch_addr_i   (fetch_addr_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_o        (instr_o),
    .instr_addr_o   (instr_addr_o),
    .instr_is_rvc_o (instr_is_rvc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [63:0] addr;
    int          n;
    logic [31:0] i0;
    logic [63:0] a0;
    logic [31:0] i1;
    logic [63:0] a1;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        rvc;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   rnd_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic void push_exp(input logic [31:0] i, input logic [63:0] a);
    exp_t e;
    e.instr = i;
    e.addr  = a;
    e.rvc   = (i[1:0] != 2'b11);
    exp_q.push_back(e);
  endfunction

  // Scoreboard: every valid cycle is compared against the queue head, so a
  // stalled output must keep matching; the head is popped on a handshake.
  always @(negedge clk) begin
    #2;
    if (mon_en && instr_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_instr: got %h @%h, expected no output", instr_o, instr_addr_o);
      end else begin
        check("instr", {32'h0, instr_o}, {32'h0, exp_q[0].instr});
        check("instr_addr", instr_addr_o, exp_q[0].addr);
        check("instr_is_rvc", {63'h0, instr_is_rvc_o}, {63'h0, exp_q[0].rvc});
        if (instr_ready_i && !flush_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [63:0] a);
    bit done;
    done = 1'b0;
    @(negedge clk);
    fetch_valid_i = 1'b1;
    fetch_data_i  = d;
    fetch_addr_i  = a;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      if (fetch_ready_o) begin
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: word %h never accepted, expected acceptance", d);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    fetch_valid_i = 1'b0;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_table();
    for (int i = 0; i < 6; i++) begin
      push_exp(vecs[i].i0, vecs[i].a0);
      if (vecs[i].n == 2) push_exp(vecs[i].i1, vecs[i].a1);
      send(vecs[i].data, vecs[i].addr);
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0001_0001, 64'h8000_0000, 2, 32'h0001, 64'h8000_0000, 32'h0001, 64'h8000_0002};
    vecs[1] = '{32'h0010_0093, 64'h8000_0000, 1, 32'h0010_0093, 64'h8000_0000, 32'h0, 64'h0};
    vecs[2] = '{32'h0093_0001, 64'h8000_0000, 1, 32'h0001, 64'h8000_0000, 32'h0, 64'h0};
    vecs[3] = '{32'h0001_0010, 64'h8000_0004, 2, 32'h0010_0093, 64'h8000_0002,
                32'h0001, 64'h8000_0006};
    vecs[4] = '{32'h0001_0093, 64'h8000_0002, 1, 32'h0001, 64'h8000_0002, 32'h0, 64'h0};
    vecs[5] = '{32'h4581_4501, 64'h8000_0008, 2, 32'h4501, 64'h8000_0008,
                32'h4581, 64'h8000_000a};

    rst_i         = 1'b1;
    flush_i       = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_data_i  = '0;
    fetch_addr_i  = '0;
    instr_ready_i = 1'b1;

    // Reset values.
    #2;
    check("rst_instr_valid", {63'h0, instr_valid_o}, 64'd0);
    check("rst_instr", {32'h0, instr_o}, 64'd0);
    check("rst_instr_addr", instr_addr_o, 64'd0);
    check("rst_is_rvc", {63'h0, instr_is_rvc_o}, 64'd0);
    check("rst_fetch_ready", {63'h0, fetch_ready_o}, 64'd1);
    @(negedge clk);
    rst_i  = 1'b0;
    mon_en = 1'b1;

    // Table pass with downstream always ready.
    run_table();

    // Two compressed in one word: fetch_ready low while the first is out.
    push_exp(32'h0001, 64'h8000_0000);
    push_exp(32'h0001, 64'h8000_0002);
    send(32'h0001_0001, 64'h8000_0000);
    @(negedge clk);
    fetch_valid_i = 1'b0;
    #1;
    check("ready_low_cycle1", {63'h0, fetch_ready_o}, 64'd0);
    drain();

    // Downstream stall for 5 cycles: outputs hold, no new word accepted.
    instr_ready_i = 1'b0;
    push_exp(32'h4501, 64'h8000_0010);
    push_exp(32'h4581, 64'h8000_0012);
    send(32'h4581_4501, 64'h8000_0010);
    @(negedge clk);
    fetch_valid_i = 1'b1;
    fetch_data_i  = 32'h0001_0001;
    fetch_addr_i  = 64'h8000_0014;
    #1;
    check("stall_fetch_ready", {63'h0, fetch_ready_o}, 64'd0);
    repeat (4) begin
      @(negedge clk);
      #1;
      check("stall_fetch_ready", {63'h0, fetch_ready_o}, 64'd0);
      check("stall_valid", {63'h0, instr_valid_o}, 64'd1);
    end
    @(negedge clk);
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b1;
    drain();

    // Table pass with random downstream backpressure.
    rnd_en = 1'b1;
    fork
      begin
        while (rnd_en) begin
          @(negedge clk);
          instr_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join_none
    run_table();
    rnd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    instr_ready_i = 1'b1;

    // Carry pending, then flush: the carry must not merge with the next word.
    push_exp(32'h0001, 64'h8000_0000);
    send(32'h0093_0001, 64'h8000_0000);
    drain();
    repeat (2) begin
      @(negedge clk);
      #1;
      check("carry_hold_no_valid", {63'h0, instr_valid_o}, 64'd0);
    end
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush_fetch_ready", {63'h0, fetch_ready_o}, 64'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("post_flush_valid", {63'h0, instr_valid_o}, 64'd0);
    push_exp(32'h0010_0093, 64'h8000_1000);
    send(32'h0010_0093, 64'h8000_1000);
    drain();

    // Asynchronous reset mid-sequence.
    push_exp(32'h0001, 64'h8000_2000);
    push_exp(32'h0001, 64'h8000_2002);
    send(32'h0001_0001, 64'h8000_2000);
    @(negedge clk);
    fetch_valid_i = 1'b0;
    instr_ready_i = 1'b0;
    #3;
    mon_en = 1'b0;
    rst_i  = 1'b1;
    #1;
    check("arst_instr_valid", {63'h0, instr_valid_o}, 64'd0);
    check("arst_instr", {32'h0, instr_o}, 64'd0);
    check("arst_instr_addr", instr_addr_o, 64'd0);
    check("arst_is_rvc", {63'h0, instr_is_rvc_o}, 64'd0);
    check("arst_fetch_ready", {63'h0, fetch_ready_o}, 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst_i         = 1'b0;
    instr_ready_i = 1'b1;
    mon_en        = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("post_rst_no_valid", {63'h0, instr_valid_o}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
